uart_autobaud: RTL and testbench

// Baud-rate acquisition and supervision controller for the AXI4-Stream UART receiver.

---
 rtl/uart_autobaud.sv | 217 +++++++++++++++++++++
 tb/tb_uart_autobaud.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// Baud-rate acquisition for the UART receiver: times four 0x55 sync periods on rxd,
// derives prescale = round(N/64), and supervises the receiver with relock on repeated frame errors.
module uart_autobaud #(
   parameter int          CNT_WIDTH        = 23,
   parameter logic [15:0] DEFAULT_PRESCALE = 16'd54,
   parameter int          GUARD            = 16,
   parameter int          TIMEOUT          = 50000000,
   parameter int          ERR_THRESH       = 4,
   parameter bit          AUTO_RELOCK      = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rxd,
   input  logic        start,
   input  logic        frame_error,
   input  logic        byte_ok,
   output logic [15:0] prescale,
   output logic        rx_rst,
   output logic        busy,
   output logic        locked,
   output logic        fail
);

   localparam int GW = $clog2(GUARD + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int EW = $clog2(ERR_THRESH + 1);
   localparam logic [GW-1:0] GUARD_V   = GW'(GUARD);
   localparam logic [WW-1:0] TIMEOUT_V = WW'(TIMEOUT);
   localparam logic [EW-1:0] ERR_V     = EW'(ERR_THRESH);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_HIGH, S_WAIT_START, S_MEASURE, S_CALC, S_LOCKED
   } state_t;

   state_t               state, state_nx;
   logic [GW-1:0]        guard_cnt, guard_nx, guard_inc;
   logic [WW-1:0]        wait_cnt, wait_nx, wait_inc;
   logic [CNT_WIDTH-1:0] meas_cnt, meas_nx;
   logic [1:0]           edge_cnt, edge_nx;
   logic [EW-1:0]        err_cnt, err_nx, err_inc;
   logic [15:0]          prescale_nx;
   logic                 rx_rst_nx, busy_nx, locked_nx, fail_nx;
   logic                 arm, abort;
   logic                 rxd_p0, rxd_p1, rxd_p2;
   logic                 fall;
   logic [CNT_WIDTH:0]   calc_p;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] n);
      sat_inc = (&n) ? n : n + CNT_WIDTH'(1);
   endfunction

   // Round-to-nearest divide by 64, one bit wider than the count so the +32 cannot wrap.
   function automatic logic [CNT_WIDTH:0] round_div64(input logic [CNT_WIDTH-1:0] n);
      round_div64 = ({1'b0, n} + (CNT_WIDTH+1)'(32)) >> 6;
   endfunction

   function automatic logic prescale_ok(input logic [CNT_WIDTH:0] p);
      prescale_ok = (p != '0) && (64'(p) <= 64'd65535);
   endfunction

   // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_p0 <= 1'b1;
         rxd_p1 <= 1'b1;
         rxd_p2 <= 1'b1;
      end else begin
         rxd_p0 <= rxd;
         rxd_p1 <= rxd_p0;
         rxd_p2 <= rxd_p1;
      end
   end

   assign fall      = rxd_p2 & ~rxd_p1;
   assign guard_inc = guard_cnt + GW'(1);
   assign wait_inc  = wait_cnt + WW'(1);
   assign err_inc   = err_cnt + EW'(1);
   assign calc_p    = round_div64(meas_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         guard_cnt <= '0;
         wait_cnt  <= '0;
         meas_cnt  <= '0;
         edge_cnt  <= '0;
         err_cnt   <= '0;
         prescale  <= DEFAULT_PRESCALE;
         rx_rst    <= 1'b0;
         busy      <= 1'b0;
         locked    <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state     <= state_nx;
         guard_cnt <= guard_nx;
         wait_cnt  <= wait_nx;
         meas_cnt  <= meas_nx;
         edge_cnt  <= edge_nx;
         err_cnt   <= err_nx;
         prescale  <= prescale_nx;
         rx_rst    <= rx_rst_nx;
         busy      <= busy_nx;
         locked    <= locked_nx;
         fail      <= fail_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      guard_nx    = guard_cnt;
      wait_nx     = wait_cnt;
      meas_nx     = meas_cnt;
      edge_nx     = edge_cnt;
      err_nx      = err_cnt;
      prescale_nx = prescale;
      rx_rst_nx   = rx_rst;
      busy_nx     = busy;
      locked_nx   = locked;
      fail_nx     = 1'b0;
      arm         = 1'b0;
      abort       = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) arm = 1'b1;
         end
         S_WAIT_HIGH: begin
            if (wait_inc == TIMEOUT_V) begin
               abort = 1'b1;
            end else begin
               wait_nx = wait_inc;
               if (!rxd_p1) begin
                  guard_nx = '0;
               end else if (guard_inc == GUARD_V) begin
                  guard_nx = '0;
                  state_nx = S_WAIT_START;
               end else begin
                  guard_nx = guard_inc;
               end
            end
         end
         S_WAIT_START: begin
            if (wait_inc == TIMEOUT_V) begin
               abort = 1'b1;
            end else begin
               wait_nx = wait_inc;
               if (fall) begin
                  meas_nx  = '0;
                  edge_nx  = '0;
                  state_nx = S_MEASURE;
               end
            end
         end
         S_MEASURE: begin
            // The closing fall cycle is still counted so meas_cnt spans exactly N cycles.
            if (fall && edge_cnt == 2'd3) begin
               meas_nx  = sat_inc(meas_cnt);
               state_nx = S_CALC;
            end else if (&meas_cnt) begin
               abort = 1'b1;
            end else begin
               meas_nx = sat_inc(meas_cnt);
               if (fall) edge_nx = edge_cnt + 2'd1;
            end
         end
         S_CALC: begin
            if (prescale_ok(calc_p)) begin
               prescale_nx = 16'(calc_p);
               state_nx    = S_LOCKED;
               locked_nx   = 1'b1;
               busy_nx     = 1'b0;
               rx_rst_nx   = 1'b0;
               err_nx      = '0;
            end else begin
               abort = 1'b1;
            end
         end
         S_LOCKED: begin
            if (start) begin
               arm = 1'b1;
            end else if (byte_ok) begin
               err_nx = '0;
            end else if (frame_error) begin
               if (err_cnt == ERR_V) begin
                  err_nx = err_cnt;
               end else if (err_inc == ERR_V) begin
                  if (AUTO_RELOCK) arm = 1'b1;
                  else err_nx = err_inc;
               end else begin
                  err_nx = err_inc;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase

      if (arm) begin
         state_nx  = S_WAIT_HIGH;
         busy_nx   = 1'b1;
         rx_rst_nx = 1'b1;
         locked_nx = 1'b0;
         wait_nx   = '0;
         guard_nx  = '0;
         err_nx    = '0;
      end
      if (abort) begin
         state_nx  = S_IDLE;
         fail_nx   = 1'b1;
         busy_nx   = 1'b0;
         rx_rst_nx = 1'b0;
         locked_nx = 1'b0;
         wait_nx   = '0;
         guard_nx  = '0;
      end
   end

endmodule

// File: tb/tb_uart_autobaud.sv
// Scoreboarded bench for uart_autobaud: stimulus queues expected lock/fail outcomes
// from a fall-interval model; a monitor pops them on each lock rise or fail pulse.
module tb_uart_autobaud;

   localparam int CW = 14;
   localparam int TO = 3000;

   logic        clk = 1'b0;
   logic        rst_n, rxd, start, frame_error, byte_ok;
   logic [15:0] prescale;
   logic        rx_rst, busy, locked, fail;

   int checks   = 0;
   int failures = 0;
   int exp_ps   = 54;

   typedef struct {
      bit          is_lock;
      logic [15:0] ps;
   } exp_t;
   exp_t q[$];

   uart_autobaud #(
      .CNT_WIDTH(CW), .DEFAULT_PRESCALE(16'd54), .GUARD(16),
      .TIMEOUT(TO), .ERR_THRESH(4), .AUTO_RELOCK(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rxd(rxd), .start(start),
      .frame_error(frame_error), .byte_ok(byte_ok),
      .prescale(prescale), .rx_rst(rx_rst), .busy(busy),
      .locked(locked), .fail(fail)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: N is the sum of the four fall-to-fall intervals.
   task automatic push_expect(input int gaps[4]);
      int   n;
      int   p;
      exp_t e;
      n = gaps[0] + gaps[1] + gaps[2] + gaps[3];
      p = (n + 32) / 64;
      if (n > (1 << CW) - 1 || p == 0 || p > 65535) begin
         e.is_lock = 1'b0;
         e.ps      = 16'(exp_ps);
      end else begin
         e.is_lock = 1'b1;
         e.ps      = 16'(p);
         exp_ps    = p;
      end
      q.push_back(e);
   endtask

   task automatic push_fail();
      exp_t e;
      e.is_lock = 1'b0;
      e.ps      = 16'(exp_ps);
      q.push_back(e);
   endtask

   task automatic wait_drain(input int budget, output int cycles);
      cycles = 0;
      while (q.size() != 0 && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic send_falls(input int gaps[4], input bit start_mid);
      for (int k = 0; k < 5; k++) begin
         int low;
         low = (k < 4) ? gaps[k] / 2 : 4;
         rxd = 1'b0;
         if (start_mid && k == 2) begin
            start = 1'b1;
            cyc(1);
            start = 1'b0;
            cyc(low - 1);
         end else begin
            cyc(low);
         end
         rxd = 1'b1;
         cyc((k < 4) ? gaps[k] - low : 4);
      end
   endtask

   task automatic run_acq(input int gaps[4], input bit do_start, input bit start_mid,
                          input int predelay);
      int c;
      if (do_start) begin
         pulse_start();
         chk("busy_after_start", busy, 1);
         chk("rx_rst_after_start", rx_rst, 1);
         chk("locked_after_start", locked, 0);
      end
      push_expect(gaps);
      cyc(predelay);
      send_falls(gaps, start_mid);
      wait_drain(200, c);
      cyc(3);
   endtask

   task automatic run_baud(input int bit_clk, input bit start_mid);
      int g[4];
      for (int k = 0; k < 4; k++) g[k] = 2 * bit_clk;
      run_acq(g, 1'b1, start_mid, 30);
   endtask

   task automatic fe_pulse(input bit fe, input bit bo);
      frame_error = fe;
      byte_ok     = bo;
      cyc(1);
      frame_error = 1'b0;
      byte_ok     = 1'b0;
      cyc(1);
   endtask

   initial begin : monitor
      logic locked_d;
      exp_t e;
      locked_d = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            locked_d = 1'b0;
         end else begin
            if (fail === 1'b1) begin
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_fail: got fail=1 expected no event");
               end else begin
                  e = q.pop_front();
                  chk("event_is_lock(fail seen)", 0, {31'b0, e.is_lock});
                  chk("fail_prescale", prescale, e.ps);
                  chk("fail_locked", locked, 0);
                  chk("fail_busy", busy, 0);
               end
            end
            if (locked === 1'b1 && !locked_d) begin
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_lock: got locked=1 expected no event");
               end else begin
                  e = q.pop_front();
                  chk("event_is_lock(lock seen)", 1, {31'b0, e.is_lock});
                  chk("lock_prescale", prescale, e.ps);
                  chk("lock_rx_rst", rx_rst, 0);
                  chk("lock_busy", busy, 0);
               end
            end
            locked_d = locked;
         end
      end
   end

   initial begin : stim
      int g[4];
      int c;
      rst_n = 1'b0; rxd = 1'b1; start = 1'b0; frame_error = 1'b0; byte_ok = 1'b0;
      cyc(3);
      chk("rst_prescale", prescale, 54);
      chk("rst_locked", locked, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rx_rst", rx_rst, 0);
      chk("rst_fail", fail, 0);
      rst_n = 1'b1;
      cyc(5);

      run_baud(432, 1'b0);
      run_baud(433, 1'b0);
      g = '{872, 872, 872, 872}; run_acq(g, 1'b1, 1'b0, 25);
      g = '{872, 872, 872, 871}; run_acq(g, 1'b1, 1'b0, 25);
      g = '{8, 8, 8, 8};         run_acq(g, 1'b1, 1'b0, 25);
      g = '{8, 8, 8, 7};         run_acq(g, 1'b1, 1'b0, 25);
      g = '{6, 6, 6, 6};         run_acq(g, 1'b1, 1'b0, 25);

      // Timeout with the line idle high, then with it stuck low.
      push_fail();
      pulse_start();
      wait_drain(TO + 100, c);
      chk("timeout_high_cycles_in_range", (c >= TO - 2 && c <= TO + 2), 1);
      cyc(5);
      rxd = 1'b0;
      cyc(5);
      push_fail();
      pulse_start();
      wait_drain(TO + 100, c);
      chk("timeout_low_cycles_in_range", (c >= TO - 2 && c <= TO + 2), 1);
      rxd = 1'b1;
      cyc(5);

      // One fall and then silence until the measurement counter saturates.
      pulse_start();
      cyc(30);
      push_fail();
      rxd = 1'b0;
      cyc(5);
      rxd = 1'b1;
      wait_drain((1 << CW) + 200, c);
      cyc(5);

      // Frame-error supervision.
      run_baud(200, 1'b0);
      for (int i = 0; i < 3; i++) fe_pulse(1'b1, 1'b0);
      fe_pulse(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) fe_pulse(1'b1, 1'b0);
      fe_pulse(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) fe_pulse(1'b1, 1'b0);
      chk("fe_cleared_locked", locked, 1);
      chk("fe_cleared_rx_rst", rx_rst, 0);
      frame_error = 1'b1;
      cyc(1);
      frame_error = 1'b0;
      chk("relock_locked", locked, 0);
      chk("relock_busy", busy, 1);
      chk("relock_rx_rst", rx_rst, 1);
      chk("relock_prescale_kept", prescale, 25);
      g = '{600, 600, 600, 600};
      run_acq(g, 1'b0, 1'b0, 30);

      run_baud(250, 1'b1);

      for (int it = 0; it < 12; it++) begin
         for (int k = 0; k < 4; k++) g[k] = int'($urandom_range(12, 500));
         run_acq(g, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(20, 80)));
      end

      // Asynchronous reset in the middle of a measurement.
      run_baud(300, 1'b0);
      pulse_start();
      cyc(30);
      rxd = 1'b0; cyc(100);
      rxd = 1'b1; cyc(100);
      rxd = 1'b0; cyc(50);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_prescale", prescale, 54);
      chk("midrst_locked", locked, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rx_rst", rx_rst, 0);
      chk("midrst_fail", fail, 0);
      exp_ps = 54;
      rxd = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(5);
      run_baud(160, 1'b0);
      chk("final_prescale", prescale, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
